// File: rtl/core_pkg.sv
// Types and constants shared between the core and the instruction fetch stage.
package core_pkg;

    localparam int PC_W   = 10;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush empties it and wins over push/pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Head comes straight from storage so decode sees a registered value.
    assign head = mem[rd_ptr];

    push_not_full_a : assert property (
        @(posedge clk) disable iff (!rstn) !(do_push && count == CNT_W'(DEPTH))
    );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited memory reads and queues returns.
module fetch_unit
    import core_pkg::*;
#(
    parameter int PC_W   = core_pkg::PC_W,
    parameter int INST_W = core_pkg::INST_W,
    parameter int DEPTH  = 2,
    parameter logic [PC_W-1:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic             inflight;
    logic [PC_W-1:0]  inflight_pc;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    logic             pop;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign pop  = inst_valid & inst_ready;
    assign push = inflight & ~redirect_valid;

    // A slot is reserved for every outstanding read, so a returning word always fits.
    assign occupancy = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);
    assign imem_req  = rstn & ~redirect_valid & (occupancy < OCC_W'(DEPTH));
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else if (imem_req) begin
            fetch_pc    <= pc_inc(fetch_pc);
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = inflight_pc;
        push_entry.inst = imem_rdata;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cold start, backpressure, redirects, wrap-around and mid-stream reset.
module tb_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [9:0]  inst_pc;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;
    int req_cnt;
    int pop_cnt = 0;
    int p0;

    fetch_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word[n] = 0x1000_0000 + n, one cycle read latency.
    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h1000_0000 + {22'b0, imem_addr};
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) req_cnt <= 0;
        else if (imem_req) req_cnt <= req_cnt + 1;
    end

    always @(posedge clk) begin
        if (rstn && inst_valid && inst_ready) pop_cnt <= pop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [9:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
        chk({tag, "_inst"}, inst, 32'h1000_0000 + 32'(pc));
    endtask

    initial begin
        rstn           = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);

        // Cold start and stream
        step();
        rstn = 1'b1;
        #4;
        chk("cold_req", 32'(imem_req), 32'd1);
        chk("cold_addr", 32'(imem_addr), 32'd0);
        step(); #4;
        chk("cold_c1_valid", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(); #4;
            chk_head("stream", 10'(k));
        end

        // Backpressure from the first valid cycle
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        step();
        inst_ready = 1'b0;
        #4;
        chk_head("bp_hold", 10'd0);
        for (int k = 0; k < 5; k++) begin
            step(); #4;
            chk_head("bp_hold", 10'd0);
            chk("bp_noreq", 32'(imem_req), 32'd0);
        end
        step();
        chk("bp_reqs", 32'(req_cnt <= 3), 32'd1);
        inst_ready = 1'b1;
        #4;
        chk_head("bp_rel", 10'd0);
        for (int k = 1; k < 6; k++) begin
            step(); #4;
            chk_head("bp_rel", 10'(k));
        end

        // Redirect with a queued entry and a response in flight
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h100;
        #4;
        chk("rd_req_blocked", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        #4;
        chk("rd_r1_valid", 32'(inst_valid), 32'd0);
        chk("rd_r1_req", 32'(imem_req), 32'd1);
        chk("rd_r1_addr", 32'(imem_addr), 32'h100);
        step(); #4;
        chk("rd_r2_valid", 32'(inst_valid), 32'd0);
        step();
        inst_ready = 1'b1;
        #4;
        chk_head("rd_r3", 10'h100);
        step(); #4;
        chk_head("rd_r4", 10'h101);
        step(); #4;
        chk_head("rd_r5", 10'h102);

        // Redirect coincident with a pop
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 10'h200;
        p0             = pop_cnt;
        #4;
        chk_head("rp_r0", 10'h103);
        step();
        redirect_valid = 1'b0;
        #4;
        chk("rp_pops", 32'(pop_cnt - p0), 32'd1);
        chk("rp_r1_valid", 32'(inst_valid), 32'd0);
        step(); #4;
        chk("rp_r2_valid", 32'(inst_valid), 32'd0);
        step(); #4;
        chk_head("rp_r3", 10'h200);
        step(); #4;
        chk_head("rp_r4", 10'h201);

        // Wrap-around of the fetch PC
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 10'h3FE;
        step();
        redirect_valid = 1'b0;
        #4;
        chk("wr_addr", 32'(imem_addr), 32'h3FE);
        step();
        step(); #4;
        chk_head("wr_0", 10'h3FE);
        step(); #4;
        chk_head("wr_1", 10'h3FF);
        step(); #4;
        chk_head("wr_2", 10'h000);
        step(); #4;
        chk_head("wr_3", 10'h001);

        // Mid-stream reset
        step();
        rstn = 1'b0;
        #1;
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_inst", inst, 32'd0);
        chk("mr_pc", 32'(inst_pc), 32'd0);
        step();
        rstn = 1'b1;
        #4;
        chk("mr_c0_req", 32'(imem_req), 32'd1);
        chk("mr_c0_addr", 32'(imem_addr), 32'd0);
        step(); #4;
        chk("mr_c1_valid", 32'(inst_valid), 32'd0);
        step(); #4;
        chk_head("mr_c2", 10'd0);
        step(); #4;
        chk_head("mr_c3", 10'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
